// File: rtl/deco_gray_pkg.sv
// Shared definitions for the Gray-switch seven-segment display block.
// Latency: none (types, constants and a pure lookup function only).
// Backpressure: not applicable.
package deco_gray_pkg;

  // Sequential binary-to-BCD converter states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } bcd_state_e;

  // All segments off (segments are active-low).
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low segment patterns for 0-F, bit0 = a ... bit6 = g.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
// Latency: WIDTH+2 cycles from start_i (LOAD, WIDTH x SHIFT, DONE).
// Backpressure: none; a new start_i aborts any conversion and restarts.
// Ports: clk_i/rst_n_i clock and async active-low reset; start_i/bin_i
// launch a conversion; busy_o high outside IDLE; done_o high in DONE, when
// bcd_o carries the finished result.
module bin2bcd_seq
  import deco_gray_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      bin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH);

  bcd_state_e        state_q, state_d;
  logic [WIDTH-1:0]  bin_q;
  logic [SR_W-1:0]   sr_q, sr_adj;
  logic [CNT_W-1:0]  cnt_q;
  logic              load_en, shift_en;

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state: a start always wins, which is how an in-flight
  // conversion gets aborted and restarted on the new value.
  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        LOAD:    state_d = SHIFT;
        SHIFT:   if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs and datapath enables.
  always_comb begin
    load_en  = (state_q == LOAD);
    shift_en = (state_q == SHIFT);
    done_o   = (state_q == DONE);
    busy_o   = (state_q != IDLE);
  end

  // Add-3 correction on every BCD nibble that is 5 or more, before the shift.
  always_comb begin
    sr_adj = sr_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (sr_q[WIDTH+4*k +: 4] >= 4'd5)
        sr_adj[WIDTH+4*k +: 4] = sr_q[WIDTH+4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bin_q <= '0;
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (start_i) bin_q <= bin_i;
      if (load_en) begin
        sr_q  <= {{BCD_W{1'b0}}, bin_q};
        cnt_q <= '0;
      end else if (shift_en) begin
        sr_q  <= {sr_adj[SR_W-2:0], 1'b0};
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bcd_o = sr_q[SR_W-1 -: BCD_W];

endmodule

// File: rtl/deco_gray_display_mux.sv
// Gray-coded switch input -> debounced binary LEDs + multiplexed 7-seg display.
// Latency: LED value 2^DEBOUNCE_BITS+3 edges after a clean input edge; decimal
// digits a further WIDTH+2 cycles. Backpressure: none, free-running outputs.
// Ports: clk_pi/rst_pi clock and async active-low reset; gray_code_pi raw
// switches; mode_pi 0=hex 1=decimal; anode_po/cathode_po active-low display
// drive; led_bin_code_po accepted binary value; change_po one-cycle pulse.
module deco_gray_display_mux
  import deco_gray_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int DIGITS        = 2,
  parameter int REFRESH_BITS  = 6,
  parameter int DEBOUNCE_BITS = 5,
  parameter int BLANK_LZ      = 0
) (
  input  logic              clk_pi,
  input  logic              rst_pi,
  input  logic [WIDTH-1:0]  gray_code_pi,
  input  logic              mode_pi,
  output logic [DIGITS-1:0] anode_po,
  output logic [6:0]        cathode_po,
  output logic [WIDTH-1:0]  led_bin_code_po,
  output logic              change_po
);

  localparam int DISP_W = 4 * DIGITS;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DEBOUNCE_BITS:0] DB_LAST = {1'b0, {DEBOUNCE_BITS{1'b1}}};

  logic [WIDTH-1:0]        gray_s1_q, gray_s2_q, gray_prev_q;
  logic                    mode_s1_q, mode_s2_q, disp_mode_q;
  logic [DEBOUNCE_BITS:0]  db_cnt_q;
  logic [WIDTH-1:0]        led_q, bin_d;
  logic                    change_q, gray_chg, accept;
  logic [REFRESH_BITS-1:0] ref_cnt_q;
  logic [IDX_W-1:0]        dig_idx_q;
  logic [DIGITS-1:0]       anode_q, anode_d;
  logic [6:0]              cathode_q, cathode_d;
  logic [DISP_W-1:0]       bcd_res, bcd_disp_q, hex_vec, disp_vec;
  logic                    bcd_busy, bcd_done;
  logic [IDX_W+1:0]        nib_base;
  logic [3:0]              nib;
  logic                    upper_zero;

  // Bit i of binary is the XOR of all Gray bits from i upward.
  always_comb begin
    bin_d = '0;
    for (int i = 0; i < WIDTH; i++) bin_d[i] = ^(gray_prev_q >> i);
  end

  assign gray_chg = (gray_s2_q != gray_prev_q);
  // Fires once per stable period: the counter saturates one past DB_LAST.
  assign accept   = !gray_chg && (db_cnt_q == DB_LAST);

  always_ff @(posedge clk_pi or negedge rst_pi) begin
    if (!rst_pi) begin
      gray_s1_q   <= '0;
      gray_s2_q   <= '0;
      gray_prev_q <= '0;
      mode_s1_q   <= 1'b0;
      mode_s2_q   <= 1'b0;
      db_cnt_q    <= '0;
      led_q       <= '0;
      change_q    <= 1'b0;
    end else begin
      gray_s1_q   <= gray_code_pi;
      gray_s2_q   <= gray_s1_q;
      gray_prev_q <= gray_s2_q;
      mode_s1_q   <= mode_pi;
      mode_s2_q   <= mode_s1_q;
      if (gray_chg)                    db_cnt_q <= '0;
      else if (!db_cnt_q[DEBOUNCE_BITS]) db_cnt_q <= db_cnt_q + 1'b1;
      change_q <= accept && (bin_d != led_q);
      if (accept) led_q <= bin_d;
    end
  end

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bcd (
    .clk_i   (clk_pi),
    .rst_n_i (rst_pi),
    .start_i (accept),
    .bin_i   (bin_d),
    .busy_o  (bcd_busy),
    .done_o  (bcd_done),
    .bcd_o   (bcd_res)
  );

  // Decimal digits only move on a finished conversion, so an aborted or
  // in-flight conversion never shows partial digits.
  always_ff @(posedge clk_pi or negedge rst_pi) begin
    if (!rst_pi)                 bcd_disp_q <= '0;
    else if (bcd_done && bcd_busy) bcd_disp_q <= bcd_res;
  end

  // Digit-slot timing; the display mode is sampled only at slot boundaries.
  always_ff @(posedge clk_pi or negedge rst_pi) begin
    if (!rst_pi) begin
      ref_cnt_q   <= '0;
      dig_idx_q   <= '0;
      disp_mode_q <= 1'b0;
    end else begin
      ref_cnt_q <= ref_cnt_q + 1'b1;
      if (&ref_cnt_q) begin
        disp_mode_q <= mode_s2_q;
        if (dig_idx_q == IDX_W'(DIGITS - 1)) dig_idx_q <= '0;
        else                                 dig_idx_q <= dig_idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    hex_vec              = '0;
    hex_vec[WIDTH-1:0]   = led_q;
    disp_vec   = disp_mode_q ? bcd_disp_q : hex_vec;
    nib_base   = {dig_idx_q, 2'b00};
    nib        = disp_vec[nib_base +: 4];
    upper_zero = ((disp_vec >> nib_base) == '0);
    cathode_d  = seg_encode(nib);
    if ((BLANK_LZ != 0) && (dig_idx_q != '0) && upper_zero) cathode_d = SEG_BLANK;
    anode_d    = ~(DIGITS'(1) << dig_idx_q);
  end

  // Anode and cathode share one register stage so they switch together.
  always_ff @(posedge clk_pi or negedge rst_pi) begin
    if (!rst_pi) begin
      anode_q   <= '1;
      cathode_q <= SEG_BLANK;
    end else begin
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
    end
  end

  assign anode_po        = anode_q;
  assign cathode_po      = cathode_q;
  assign led_bin_code_po = led_q;
  assign change_po       = change_q;

endmodule

// File: tb/tb_deco_gray_display_mux.sv
module tb_deco_gray_display_mux;
  import deco_gray_pkg::*;

  localparam int WIDTH         = 4;
  localparam int DIGITS        = 2;
  localparam int REFRESH_BITS  = 2;
  localparam int DEBOUNCE_BITS = 2;
  localparam int BLANK_LZ      = 0;
  localparam int LAT           = (1 << DEBOUNCE_BITS) + 3;

  logic              clk_pi = 1'b0;
  logic              rst_pi;
  logic [WIDTH-1:0]  gray_code_pi;
  logic              mode_pi;
  logic [DIGITS-1:0] anode_po;
  logic [6:0]        cathode_po;
  logic [WIDTH-1:0]  led_bin_code_po;
  logic              change_po;

  deco_gray_display_mux #(
    .WIDTH         (WIDTH),
    .DIGITS        (DIGITS),
    .REFRESH_BITS  (REFRESH_BITS),
    .DEBOUNCE_BITS (DEBOUNCE_BITS),
    .BLANK_LZ      (BLANK_LZ)
  ) dut (
    .clk_pi          (clk_pi),
    .rst_pi          (rst_pi),
    .gray_code_pi    (gray_code_pi),
    .mode_pi         (mode_pi),
    .anode_po        (anode_po),
    .cathode_po      (cathode_po),
    .led_bin_code_po (led_bin_code_po),
    .change_po       (change_po)
  );

  always #5 clk_pi = ~clk_pi;

  int cyc = 0;
  always @(posedge clk_pi) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulse  = 0;

  typedef struct {
    logic [WIDTH-1:0] val;
    int               due;
  } exp_t;
  exp_t             sb[$];
  logic [WIDTH-1:0] mdl_led = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Drive a clean Gray value; queue an expected LED update if it differs.
  task automatic drive_gray(input logic [WIDTH-1:0] g);
    exp_t e;
    gray_code_pi = g;
    if (g2b(g) != mdl_led) begin
      e.val = g2b(g);
      e.due = cyc + LAT;
      sb.push_back(e);
      mdl_led = g2b(g);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_pi);
  endtask

  // Sample one full refresh round; return the pattern seen on each digit.
  task automatic grab(output logic [6:0] d0, output logic [6:0] d1);
    int          last_t = -1;
    int          bad    = 0;
    logic [1:0]  last_a;
    d0 = 7'h00;
    d1 = 7'h00;
    last_a = anode_po;
    repeat (16) begin
      @(negedge clk_pi);
      if (anode_po == 2'b10)      d0 = cathode_po;
      else if (anode_po == 2'b01) d1 = cathode_po;
      else                        bad++;
      if (anode_po != last_a) begin
        if (last_t >= 0) check("slot_len", cyc - last_t, 4);
        last_t = cyc;
        last_a = anode_po;
      end
    end
    check("anode_onehot", bad, 0);
  endtask

  // Output monitor: each change pulse pops the scoreboard.
  bit after_pulse = 1'b0;
  always @(negedge clk_pi) begin
    if (rst_pi === 1'b1) begin
      if (after_pulse) begin
        check("change_one_cycle", change_po, 0);
        after_pulse = 1'b0;
      end else if (change_po) begin
        exp_t e;
        n_pulse++;
        after_pulse = 1'b1;
        if (sb.size() == 0) begin
          check("spurious_change", 1, 0);
        end else begin
          e = sb.pop_front();
          check("led_value", led_bin_code_po, e.val);
          check("led_latency", cyc, e.due);
        end
      end
    end
  end

  logic [6:0] d0, d1;
  int         p0;

  initial begin
    rst_pi       = 1'b0;
    gray_code_pi = '0;
    mode_pi      = 1'b0;
    wait_cyc(3);
    check("rst_anode", anode_po, 2'b11);
    check("rst_cathode", cathode_po, 7'b1111111);
    check("rst_led", led_bin_code_po, 0);
    check("rst_change", change_po, 0);
    check("rst_fsm", 32'(dut.u_bcd.state_q), 32'(IDLE));
    rst_pi = 1'b1;
    wait_cyc(10);
    check("idle_no_pulse", n_pulse, 0);

    // Clean value: 0101 -> 0110.
    drive_gray(4'b0101);
    wait_cyc(12);
    check("sb_drain_a", sb.size(), 0);
    check("led_0110", led_bin_code_po, 4'b0110);
    check("pulses_a", n_pulse, 1);

    // Back to zero, then a 3-cycle glitch that must be rejected.
    drive_gray(4'b0000);
    wait_cyc(12);
    p0 = n_pulse;
    gray_code_pi = 4'b0001;
    wait_cyc(3);
    gray_code_pi = 4'b0000;
    wait_cyc(15);
    check("glitch_led", led_bin_code_po, 0);
    check("glitch_no_pulse", n_pulse, p0);

    // Hex display of 1111.
    drive_gray(4'b1000);
    wait_cyc(14);
    check("sb_drain_b", sb.size(), 0);
    grab(d0, d1);
    check("hex_d0_F", d0, 7'b0001110);
    check("hex_d1", d1, (BLANK_LZ != 0) ? 7'b1111111 : 7'b1000000);

    // Decimal display of 15.
    mode_pi = 1'b1;
    wait_cyc(12);
    grab(d0, d1);
    check("dec_d0_5", d0, 7'b0010010);
    check("dec_d1_1", d1, 7'b1111001);

    // Reset in the middle of a conversion.
    drive_gray(4'b0101);
    wait_cyc(LAT + 1);
    check("in_shift", 32'(dut.u_bcd.state_q), 32'(SHIFT));
    rst_pi  = 1'b0;
    mdl_led = '0;
    wait_cyc(2);
    check("mid_rst_fsm", 32'(dut.u_bcd.state_q), 32'(IDLE));
    check("mid_rst_bcd", dut.bcd_disp_q, 0);
    check("mid_rst_led", led_bin_code_po, 0);
    check("mid_rst_anode", anode_po, 2'b11);
    gray_code_pi = 4'b0000;
    wait_cyc(1);
    rst_pi = 1'b1;
    wait_cyc(20);
    grab(d0, d1);
    check("post_rst_d0", d0, 7'b1000000);
    check("post_rst_d1", d1, (BLANK_LZ != 0) ? 7'b1111111 : 7'b1000000);
    check("post_rst_led", led_bin_code_po, 0);
    check("sb_drain_c", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
